mcyc_ctrl_fsm: RTL

Parametrised multi-cycle MIPS32 control unit. It drives every datapath enable and mux select in the multi-cycle core, and it replaces the fixed one-cycle-per-step control with a memory ready handshake, an optional memory timeout and a retired-instruction counter. It sits beside the datapath top. It takes op, func and the ALU zero flag, and it drives IR/MDR/A/B/ALUOut enables, the mux selects, RegWrite, PCWrite and the memory strobes.

---
 rtl/mcyc_pkg.sv | 75 +++++++
 rtl/mcyc_wait_timer.sv | 44 ++++
 rtl/mcyc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcyc_pkg.sv
// ============================================================================
// Module  : mcyc_pkg
// Brief   : Shared state, opcode, function, ALU and mux-select codes for the
//           multi-cycle MIPS32 control unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mcyc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch    = 4'd0;
    localparam state_t c_st_decode   = 4'd1;
    localparam state_t c_st_mem_addr = 4'd2;
    localparam state_t c_st_mem_rd   = 4'd3;
    localparam state_t c_st_mem_wb   = 4'd4;
    localparam state_t c_st_mem_wr   = 4'd5;
    localparam state_t c_st_exec_r   = 4'd6;
    localparam state_t c_st_r_wb     = 4'd7;
    localparam state_t c_st_branch   = 4'd8;
    localparam state_t c_st_jump     = 4'd9;
    localparam state_t c_st_exec_i   = 4'd10;
    localparam state_t c_st_i_wb     = 4'd11;
    localparam state_t c_st_illegal  = 4'd12;
    localparam state_t c_st_trap     = 4'd13;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll = 6'h00;
    localparam logic [5:0] c_fn_srl = 6'h02;
    localparam logic [5:0] c_fn_jr  = 6'h08;
    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_nor = 6'h27;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    localparam logic [3:0] c_alu_and = 4'd0;
    localparam logic [3:0] c_alu_or  = 4'd1;
    localparam logic [3:0] c_alu_add = 4'd2;
    localparam logic [3:0] c_alu_sll = 4'd3;
    localparam logic [3:0] c_alu_srl = 4'd4;
    localparam logic [3:0] c_alu_sub = 4'd6;
    localparam logic [3:0] c_alu_slt = 4'd7;
    localparam logic [3:0] c_alu_nor = 4'd12;

    localparam logic [2:0] c_srcb_regb     = 3'd0;
    localparam logic [2:0] c_srcb_shamt    = 3'd1;
    localparam logic [2:0] c_srcb_sext     = 3'd2;
    localparam logic [2:0] c_srcb_sext_sh2 = 3'd3;
    localparam logic [2:0] c_srcb_four     = 3'd4;
    localparam logic [2:0] c_srcb_zext     = 3'd5;

    localparam logic [2:0] c_pc_alu    = 3'd0;
    localparam logic [2:0] c_pc_aluout = 3'd1;
    localparam logic [2:0] c_pc_jump   = 3'd2;
    localparam logic [2:0] c_pc_rega   = 3'd3;

    function automatic logic is_mem_state(input state_t s);
        return (s == c_st_fetch) || (s == c_st_mem_rd) || (s == c_st_mem_wr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcyc_wait_timer.sv
// ============================================================================
// Module  : mcyc_wait_timer
// Brief   : Counts memory wait cycles and flags a timeout once WAIT_TIMEOUT
//           cycles have elapsed; WAIT_TIMEOUT = 0 disables the timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcyc_wait_timer #(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int c_cnt_w = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_wait) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // r_cnt holds completed wait cycles, so the timeout lands on the cycle after the limit.
    generate
        if (WAIT_TIMEOUT > 0) begin : g_timeout_on
            assign o_timeout = i_wait && (r_cnt == c_cnt_w'(WAIT_TIMEOUT));
        end else begin : g_timeout_off
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mcyc_ctrl_fsm.sv
// ============================================================================
// Module  : mcyc_ctrl_fsm
// Brief   : Multi-cycle MIPS32 control FSM with memory ready handshake,
//           optional wait timeout and retired-instruction counter.
//           Build option: MCYC_ILLEGAL_TRAP_EN enables the illegal-opcode trap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mcyc_ctrl_fsm
    import mcyc_pkg::*;
#(
    parameter int ALUOP_W      = 4,
    parameter int SRCB_W       = 3,
    parameter int PCSRC_W      = 3,
    parameter int WAIT_TIMEOUT = 0,
    parameter int CNT_W        = 32
) (
    input  logic               MAX10_CLK1_50,
    input  logic               nrst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               mdr_we,
    output logic               rega_we,
    output logic               regb_we,
    output logic               alu_result_we,
    output logic               alu_src_a,
    output logic [SRCB_W-1:0]  alu_src_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [PCSRC_W-1:0] pc_src,
    output logic               pc_write,
    output logic               bus_err,
    output logic [CNT_W-1:0]   instr_count,
    output logic               trap
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_retire;
    logic             w_wait;
    logic             w_clear;
    logic             w_timeout;
    logic [CNT_W-1:0] r_instr_count;

    assign w_wait  = is_mem_state(r_state) && !mem_ready;
    // A timeout out of FETCH re-enters FETCH, so it must clear the counter too.
    assign w_clear = (w_next_state != r_state) || w_timeout;

    mcyc_wait_timer #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk      (MAX10_CLK1_50),
        .rst_n    (nrst),
        .i_wait   (w_wait),
        .i_clear  (w_clear),
        .o_timeout(w_timeout)
    );

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_we         = 1'b0;
        mdr_we        = 1'b0;
        rega_we       = 1'b0;
        regb_we       = 1'b0;
        alu_result_we = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = '0;
        aluop         = '0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_src        = '0;
        pc_write      = 1'b0;
        bus_err       = 1'b0;
        trap          = 1'b0;
        w_retire      = 1'b0;
        w_next_state  = r_state;
        if (nrst) begin
            case (r_state)
                c_st_fetch: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we        = 1'b1;
                        alu_src_b    = SRCB_W'(c_srcb_four);
                        aluop        = ALUOP_W'(c_alu_add);
                        pc_src       = PCSRC_W'(c_pc_alu);
                        pc_write     = 1'b1;
                        w_next_state = c_st_decode;
                    end else if (w_timeout) begin
                        bus_err = 1'b1;
                    end
                end
                c_st_decode: begin
                    rega_we       = 1'b1;
                    regb_we       = 1'b1;
                    alu_src_b     = SRCB_W'(c_srcb_sext_sh2);
                    aluop         = ALUOP_W'(c_alu_add);
                    alu_result_we = 1'b1;
                    case (op)
                        c_op_lw, c_op_sw:               w_next_state = c_st_mem_addr;
                        c_op_rtype:                     w_next_state = c_st_exec_r;
                        c_op_beq, c_op_bne:             w_next_state = c_st_branch;
                        c_op_j:                         w_next_state = c_st_jump;
                        c_op_addi, c_op_andi, c_op_ori: w_next_state = c_st_exec_i;
                        default:                        w_next_state = c_st_illegal;
                    endcase
                end
                c_st_mem_addr: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_W'(c_srcb_sext);
                    aluop         = ALUOP_W'(c_alu_add);
                    alu_result_we = 1'b1;
                    w_next_state  = (op == c_op_lw) ? c_st_mem_rd : c_st_mem_wr;
                end
                c_st_mem_rd: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        mdr_we       = 1'b1;
                        w_next_state = c_st_mem_wb;
                    end else if (w_timeout) begin
                        bus_err      = 1'b1;
                        w_next_state = c_st_fetch;
                    end
                end
                c_st_mem_wb: begin
                    mem_to_reg   = 1'b1;
                    reg_write    = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
                end
                c_st_mem_wr: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        w_retire     = 1'b1;
                        w_next_state = c_st_fetch;
                    end else if (w_timeout) begin
                        bus_err      = 1'b1;
                        w_next_state = c_st_fetch;
                    end
                end
                c_st_exec_r: begin
                    if (func == c_fn_jr) begin
                        pc_src       = PCSRC_W'(c_pc_rega);
                        pc_write     = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = c_st_fetch;
                    end else begin
                        alu_src_a     = 1'b1;
                        alu_result_we = 1'b1;
                        w_next_state  = c_st_r_wb;
                        case (func)
                            c_fn_sll: begin
                                alu_src_b = SRCB_W'(c_srcb_shamt);
                                aluop     = ALUOP_W'(c_alu_sll);
                            end
                            c_fn_srl: begin
                                alu_src_b = SRCB_W'(c_srcb_shamt);
                                aluop     = ALUOP_W'(c_alu_srl);
                            end
                            c_fn_sub: aluop = ALUOP_W'(c_alu_sub);
                            c_fn_and: aluop = ALUOP_W'(c_alu_and);
                            c_fn_or:  aluop = ALUOP_W'(c_alu_or);
                            c_fn_slt: aluop = ALUOP_W'(c_alu_slt);
                            c_fn_nor: aluop = ALUOP_W'(c_alu_nor);
                            default:  aluop = ALUOP_W'(c_alu_add);
                        endcase
                    end
                end
                c_st_r_wb: begin
                    reg_dst      = 1'b1;
                    reg_write    = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
                end
                c_st_branch: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_W'(c_srcb_regb);
                    aluop        = ALUOP_W'(c_alu_sub);
                    pc_src       = PCSRC_W'(c_pc_aluout);
                    pc_write     = (op == c_op_bne) ? !zero : zero;
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
                end
                c_st_jump: begin
                    pc_src       = PCSRC_W'(c_pc_jump);
                    pc_write     = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
                end
                c_st_exec_i: begin
                    alu_src_a     = 1'b1;
                    alu_result_we = 1'b1;
                    w_next_state  = c_st_i_wb;
                    case (op)
                        c_op_addi: begin
                            alu_src_b = SRCB_W'(c_srcb_sext);
                            aluop     = ALUOP_W'(c_alu_add);
                        end
                        c_op_andi: begin
                            alu_src_b = SRCB_W'(c_srcb_zext);
                            aluop     = ALUOP_W'(c_alu_and);
                        end
                        default: begin
                            alu_src_b = SRCB_W'(c_srcb_zext);
                            aluop     = ALUOP_W'(c_alu_or);
                        end
                    endcase
                end
                c_st_i_wb: begin
                    reg_write    = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
                end
                c_st_illegal: begin
`ifdef MCYC_ILLEGAL_TRAP_EN
                    w_next_state = c_st_trap;
`else
                    w_retire     = 1'b1;
                    w_next_state = c_st_fetch;
`endif
                end
`ifdef MCYC_ILLEGAL_TRAP_EN
                c_st_trap: begin
                    trap = 1'b1;
                end
`endif
                default: begin
                    w_next_state = c_st_fetch;
                end
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge nrst) begin
        if (!nrst) begin
            r_state       <= c_st_fetch;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign instr_count = r_instr_count;

endmodule

`default_nettype wire
